// File: rtl/datapath_sequencer.sv
// datapath_sequencer: accepts one instruction word per valid/ready handshake,
// drives the integer datapath control inputs for rpt+1 cycles, captures the
// flags and last ALU result, then pulses done for one cycle.
//
// Handshake: a word is accepted on a rising edge where instr_valid and
// instr_ready are both high; instr_ready is high only in IDLE with reset
// released, and instr_valid is ignored in every other state.
module datapath_sequencer #(
  parameter int DATA_W = 16,
  parameter int ADR_W  = 3,
  parameter int OP_W   = 4,
  parameter int RPT_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [OP_W-1:0]   i_op,
  input  logic [ADR_W-1:0]  i_wadr,
  input  logic [ADR_W-1:0]  i_radr,
  input  logic [ADR_W-1:0]  i_sadr,
  input  logic              i_ssel,
  input  logic [DATA_W-1:0] i_imm,
  input  logic              i_wb,
  input  logic [RPT_W-1:0]  i_rpt,
  input  logic              abort,
  input  logic [DATA_W-1:0] dp_alu_out,
  input  logic              dp_c,
  input  logic              dp_n,
  input  logic              dp_z,
  output logic              W_En,
  output logic              S_Sel,
  output logic [ADR_W-1:0]  W_Adr,
  output logic [ADR_W-1:0]  R_Adr,
  output logic [ADR_W-1:0]  S_Adr,
  output logic [OP_W-1:0]   Alu_Op,
  output logic [DATA_W-1:0] DS,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              flag_c,
  output logic              flag_n,
  output logic              flag_z,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic [RPT_W-1:0]    r_cnt;
  logic                r_wb;
  logic                r_ssel;
  logic [OP_W-1:0]     r_op;
  logic [ADR_W-1:0]    r_wadr;
  logic [ADR_W-1:0]    r_radr;
  logic [ADR_W-1:0]    r_sadr;
  logic [DATA_W-1:0]   r_imm;
  logic [DATA_W-1:0]   r_result;
  logic                r_c;
  logic                r_n;
  logic                r_z;
  logic                r_busy;
  logic                r_done;
  logic                w_accept;
  logic                w_exec_step;

  assign instr_ready = (r_state == ST_IDLE) & reset;
  assign w_accept    = instr_valid & instr_ready;
  // An EXEC cycle that is not cancelled commits flags (and result on the last one).
  assign w_exec_step = (r_state == ST_EXEC) & ~abort;

  // Sequencer FSM: latches the instruction, counts iterations, captures flags/result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_wb     <= 1'b0;
      r_ssel   <= 1'b0;
      r_op     <= '0;
      r_wadr   <= '0;
      r_radr   <= '0;
      r_sadr   <= '0;
      r_imm    <= '0;
      r_result <= '0;
      r_c      <= 1'b0;
      r_n      <= 1'b0;
      r_z      <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_op    <= i_op;
            r_wadr  <= i_wadr;
            r_radr  <= i_radr;
            r_sadr  <= i_sadr;
            r_ssel  <= i_ssel;
            r_imm   <= i_imm;
            r_wb    <= i_wb;
            r_cnt   <= i_rpt;
            r_busy  <= 1'b1;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (abort) begin
            // Cancelled: previous flags/result stay, no done pulse.
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_c <= dp_c;
            r_n <= dp_n;
            r_z <= dp_z;
            if (r_cnt == '0) begin
              r_result <= dp_alu_out;
              r_done   <= 1'b1;
              r_state  <= ST_DONE;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Write enable is combinational so reset or abort drops it within the cycle.
  assign W_En      = (r_state == ST_EXEC) & r_wb & ~abort;
  assign S_Sel     = r_ssel;
  assign W_Adr     = r_wadr;
  assign R_Adr     = r_radr;
  assign S_Adr     = r_sadr;
  assign Alu_Op    = r_op;
  assign DS        = r_imm;
  assign busy      = r_busy;
  assign done      = r_done;
  assign result    = r_result;
  assign flag_c    = r_c;
  assign flag_n    = r_n;
  assign flag_z    = r_z;
  assign dbg_state = r_state;

  // w_exec_step documents the commit condition for anyone binding checkers.
  logic w_unused;
  assign w_unused = w_exec_step;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Bench for datapath_sequencer: a small register-file/ALU stub plays the
// datapath, a cycle-count model predicts every output, and directed tests
// pin the model with hand-computed values.
module tb_datapath_sequencer;
  localparam int DW = 16;
  localparam int AW = 3;
  localparam int OW = 4;
  localparam int RW = 4;
  localparam logic [OW-1:0] OP_ADD = 4'd0;
  localparam logic [OW-1:0] OP_SUB = 4'd1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic rf_load = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic [OW-1:0] i_op = '0;
  logic [AW-1:0] i_wadr = '0, i_radr = '0, i_sadr = '0;
  logic          i_ssel = 1'b0;
  logic [DW-1:0] i_imm = '0;
  logic          i_wb = 1'b0;
  logic [RW-1:0] i_rpt = '0;
  logic          abort = 1'b0;
  logic [DW-1:0] dp_alu_out;
  logic          dp_c, dp_n, dp_z;
  logic          W_En, S_Sel;
  logic [AW-1:0] W_Adr, R_Adr, S_Adr;
  logic [OW-1:0] Alu_Op;
  logic [DW-1:0] DS, result;
  logic          busy, done, flag_c, flag_n, flag_z;
  logic [1:0]    dbg_state;

  datapath_sequencer #(.DATA_W(DW), .ADR_W(AW), .OP_W(OW), .RPT_W(RW)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .i_op(i_op), .i_wadr(i_wadr), .i_radr(i_radr), .i_sadr(i_sadr), .i_ssel(i_ssel),
    .i_imm(i_imm), .i_wb(i_wb), .i_rpt(i_rpt), .abort(abort),
    .dp_alu_out(dp_alu_out), .dp_c(dp_c), .dp_n(dp_n), .dp_z(dp_z),
    .W_En(W_En), .S_Sel(S_Sel), .W_Adr(W_Adr), .R_Adr(R_Adr), .S_Adr(S_Adr),
    .Alu_Op(Alu_Op), .DS(DS), .busy(busy), .done(done), .result(result),
    .flag_c(flag_c), .flag_n(flag_n), .flag_z(flag_z), .dbg_state(dbg_state)
  );

  // ---------------- datapath definition (shared by stub and model) ----------------
  function automatic logic [DW:0] alu(input logic [OW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (op)
      OP_ADD:  alu = {1'b0, a} + {1'b0, b};
      OP_SUB:  alu = {1'b0, a} - {1'b0, b};
      default: alu = {1'b0, a & b};
    endcase
  endfunction

  function automatic logic [DW-1:0] rf_init(input int i);
    case (i)
      1:       rf_init = 16'h000A;
      2:       rf_init = 16'h1234;
      4:       rf_init = 16'h0010;
      5:       rf_init = 16'hFFFC;
      default: rf_init = 16'h0000;
    endcase
  endfunction

  // Datapath stub driven by the DUT's control outputs.
  logic [DW-1:0] rf_dp [8];
  logic [DW:0]   dp_full;
  always_comb dp_full = alu(Alu_Op, rf_dp[R_Adr], S_Sel ? DS : rf_dp[S_Adr]);
  assign dp_alu_out = dp_full[DW-1:0];
  assign dp_c = dp_full[DW];
  assign dp_n = dp_full[DW-1];
  assign dp_z = (dp_full[DW-1:0] == '0);
  always @(posedge clk) begin
    if (rf_load) begin
      for (int i = 0; i < 8; i++) rf_dp[i] <= rf_init(i);
    end else if (W_En) begin
      rf_dp[W_Adr] <= dp_alu_out;
    end
  end

  // ---------------- behavioural model ----------------
  // An accepted word executes in the rpt+1 cycles after its accept edge,
  // then one done cycle, then the sequencer is free again.
  logic          m_act = 1'b0;
  int            m_r = 0, m_rpt = 0;
  logic [OW-1:0] m_op = '0;
  logic [AW-1:0] m_w = '0, m_ra = '0, m_sa = '0;
  logic          m_ssel = 1'b0, m_wb = 1'b0;
  logic [DW-1:0] m_imm = '0, m_res = '0;
  logic          m_c = 1'b0, m_n = 1'b0, m_z = 1'b0;
  logic [DW-1:0] mrf [8];
  logic [DW:0]   mv;
  logic [DW-1:0] exp_q [$];
  assign mv = alu(m_op, mrf[m_ra], m_ssel ? m_imm : mrf[m_sa]);

  always @(posedge clk or negedge reset) begin
    if (rf_load) begin
      for (int i = 0; i < 8; i++) mrf[i] <= rf_init(i);
    end
    if (!reset) begin
      m_act <= 1'b0; m_r <= 0; m_rpt <= 0;
      m_op <= '0; m_w <= '0; m_ra <= '0; m_sa <= '0;
      m_ssel <= 1'b0; m_wb <= 1'b0; m_imm <= '0;
      m_res <= '0; m_c <= 1'b0; m_n <= 1'b0; m_z <= 1'b0;
    end else if (m_act) begin
      if (m_r <= m_rpt) begin
        if (abort) begin
          m_act <= 1'b0;
        end else begin
          m_c <= mv[DW];
          m_n <= mv[DW-1];
          m_z <= (mv[DW-1:0] == '0);
          if (m_wb) mrf[m_w] <= mv[DW-1:0];
          if (m_r == m_rpt) begin
            m_res <= mv[DW-1:0];
            exp_q.push_back(mv[DW-1:0]);
          end
          m_r <= m_r + 1;
        end
      end else begin
        m_act <= 1'b0;
      end
    end else if (instr_valid) begin
      m_act <= 1'b1; m_r <= 0; m_rpt <= int'(i_rpt);
      m_op <= i_op; m_w <= i_wadr; m_ra <= i_radr; m_sa <= i_sadr;
      m_ssel <= i_ssel; m_wb <= i_wb; m_imm <= i_imm;
    end
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail = 0;
  int wen_cnt = 0;
  int done_cnt = 0;
  int acc_q [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Per-cycle compare, sampled one time unit after the falling edge.
  initial begin : compare
    logic exec;
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      #1;
      exec = m_act && (m_r <= m_rpt);
      chk("instr_ready", 32'(instr_ready), 32'(reset && !m_act));
      chk("W_En", 32'(W_En), 32'(exec && m_wb && !abort));
      chk("done", 32'(done), 32'(m_act && (m_r == m_rpt + 1)));
      chk("busy", 32'(busy), 32'(m_act));
      chk("result", 32'(result), 32'(m_res));
      chk("flags", {29'd0, flag_c, flag_n, flag_z}, {29'd0, m_c, m_n, m_z});
      chk("Alu_Op", 32'(Alu_Op), 32'(m_op));
      chk("addrs", {23'd0, W_Adr, R_Adr, S_Adr}, {23'd0, m_w, m_ra, m_sa});
      chk("S_Sel", 32'(S_Sel), 32'(m_ssel));
      chk("DS", 32'(DS), 32'(m_imm));
      if (W_En) wen_cnt++;
      if (done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          chk("done_unexpected", 32'(done), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("done_result", 32'(result), 32'(e));
        end
      end
      if (instr_valid && instr_ready) acc_q.push_back(cyc);
    end
  end

  // ---------------- driver ----------------
  // Called at a falling edge; returns at the falling edge after the accept edge.
  task automatic send(input logic [OW-1:0] op, input logic [AW-1:0] w, input logic [AW-1:0] r,
                      input logic [AW-1:0] s, input logic ssel, input logic [DW-1:0] imm,
                      input logic wb, input logic [RW-1:0] rpt, input logic hold);
    logic ok;
    i_op = op; i_wadr = w; i_radr = r; i_sadr = s; i_ssel = ssel;
    i_imm = imm; i_wb = wb; i_rpt = rpt; instr_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      #1;
      if (instr_ready) ok = 1'b1;
      @(negedge clk);
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    if (!hold) instr_valid = 1'b0;
  endtask

  // ---------------- directed tests ----------------
  int w0, d0;
  initial begin : main
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", 32'(instr_ready), 32'd0);
    chk("rst_wen_done", {30'd0, W_En, done}, 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    @(negedge clk);
    reset = 1'b1; rf_load = 1'b0;
    @(negedge clk);

    // T1: reset during the 2nd EXEC cycle of a rpt=5 instruction
    d0 = done_cnt;
    send(OP_ADD, 3'd6, 3'd6, 3'd0, 1'b1, 16'h0001, 1'b1, 4'd5, 1'b0);
    @(negedge clk);
    #3 reset = 1'b0;
    #1;
    chk("t1_wen", 32'(W_En), 32'd0);
    chk("t1_ready", 32'(instr_ready), 32'd0);
    chk("t1_outs", {13'd0, busy, done, flag_c, flag_n, flag_z, W_Adr, R_Adr, Alu_Op}, 32'd0);
    chk("t1_ds_res", {DS, result}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("t1_ready_after", 32'(instr_ready), 32'd1);
    chk("t1_no_done", 32'(done_cnt - d0), 32'd0);
    @(negedge clk);

    // T2: R3 = R1 + 5, single execution
    w0 = wen_cnt; d0 = done_cnt;
    send(OP_ADD, 3'd3, 3'd1, 3'd0, 1'b1, 16'h0005, 1'b1, 4'd0, 1'b0);
    #1;
    chk("t2_wen", 32'(W_En), 32'd1);
    chk("t2_wadr", 32'(W_Adr), 32'd3);
    chk("t2_ds", 32'(DS), 32'h0005);
    @(negedge clk); #1;
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_result", 32'(result), 32'h000F);
    chk("t2_z", 32'(flag_z), 32'd0);
    @(negedge clk);
    chk("t2_wen_cnt", 32'(wen_cnt - w0), 32'd1);

    // T3: R4 = R4 + 1, four executions (0x11..0x14)
    w0 = wen_cnt; d0 = done_cnt;
    send(OP_ADD, 3'd4, 3'd4, 3'd0, 1'b1, 16'h0001, 1'b1, 4'd3, 1'b0);
    repeat (4) @(negedge clk);
    #1;
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_result", 32'(result), 32'h0014);
    @(negedge clk);
    chk("t3_wen_cnt", 32'(wen_cnt - w0), 32'd4);
    chk("t3_done_cnt", 32'(done_cnt - d0), 32'd1);

    // T4: compare R2 - R2, flags only
    w0 = wen_cnt;
    send(OP_SUB, 3'd2, 3'd2, 3'd2, 1'b0, 16'h0000, 1'b0, 4'd0, 1'b0);
    @(negedge clk); #1;
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_z", 32'(flag_z), 32'd1);
    @(negedge clk);
    chk("t4_wen_cnt", 32'(wen_cnt - w0), 32'd0);

    // T5: R5 = R5 + 2 from 0xFFFC, rpt=7, abort on 3rd EXEC cycle
    w0 = wen_cnt; d0 = done_cnt;
    send(OP_ADD, 3'd5, 3'd5, 3'd0, 1'b1, 16'h0002, 1'b1, 4'd7, 1'b0);
    repeat (2) @(negedge clk);
    abort = 1'b1;
    #1;
    chk("t5_wen_abort", 32'(W_En), 32'd0);
    @(negedge clk);
    abort = 1'b0;
    #1;
    chk("t5_ready", 32'(instr_ready), 32'd1);
    chk("t5_flags", {29'd0, flag_c, flag_n, flag_z}, 32'b101);
    chk("t5_result_kept", 32'(result), 32'h0000);
    repeat (2) @(negedge clk);
    chk("t5_wen_cnt", 32'(wen_cnt - w0), 32'd2);
    chk("t5_no_done", 32'(done_cnt - d0), 32'd0);

    // T6: three words back to back with instr_valid held high
    d0 = done_cnt;
    acc_q.delete();
    send(OP_ADD, 3'd7, 3'd1, 3'd0, 1'b1, 16'h0001, 1'b1, 4'd0, 1'b1);
    send(OP_ADD, 3'd7, 3'd7, 3'd0, 1'b1, 16'h0001, 1'b1, 4'd0, 1'b1);
    send(OP_SUB, 3'd0, 3'd7, 3'd1, 1'b0, 16'h0000, 1'b1, 4'd0, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    chk("t6_done_cnt", 32'(done_cnt - d0), 32'd3);
    chk("t6_result", 32'(result), 32'h0002);
    chk("t6_acc_cnt", 32'(acc_q.size()), 32'd3);
    if (acc_q.size() == 3) begin
      chk("t6_spacing1", 32'(acc_q[1] - acc_q[0]), 32'd3);
      chk("t6_spacing2", 32'(acc_q[2] - acc_q[1]), 32'd3);
    end
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
